// File: rtl/digit_scan_driver.sv
// Multiplexed display digit scanner: drives one active-low digit at a time with blank gaps.
// Optional macro DIGIT_SCAN_DEAD_TIME_EN inserts DEAD_CYCLES all-blank cycles between digits.
module digit_scan_driver #(
   parameter int N_DIGITS     = 4,
   parameter int DWELL_CYCLES = 50000,
   parameter int DEAD_CYCLES  = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        ON,
   input  logic [N_DIGITS-1:0]         mask,
   output logic [N_DIGITS-1:0]         digit,
   output logic [$clog2(N_DIGITS)-1:0] sel,
   output logic                        frame_done
);

   localparam int SEL_W   = $clog2(N_DIGITS);
   localparam int CNT_MAX = (DWELL_CYCLES > DEAD_CYCLES) ? DWELL_CYCLES : DEAD_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;
   localparam logic [N_DIGITS-1:0] ONE_HOT0 = N_DIGITS'(1);

`ifdef DIGIT_SCAN_DEAD_TIME_EN
   typedef enum logic [1:0] {IDLE, DEAD, DRIVE} state_t;
`else
   typedef enum logic [1:0] {IDLE, DRIVE} state_t;
`endif

   state_t               r_state, w_state_nxt;
   logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
   logic [SEL_W-1:0]     r_sel, w_sel_nxt;
   logic [N_DIGITS-1:0]  r_digit, w_digit_nxt;
   logic                 r_frame_done, w_frame_nxt;
   logic                 w_run;

   function automatic logic [SEL_W-1:0] f_lowest(input logic [N_DIGITS-1:0] m);
      logic [SEL_W-1:0] r;
      r = '0;
      for (int i = N_DIGITS - 1; i >= 0; i--)
         if (m[i]) r = SEL_W'(i);
      return r;
   endfunction

   // Circular search strictly above cur; falls back to cur itself when it is the only set bit.
   function automatic logic [SEL_W-1:0] f_next(input logic [N_DIGITS-1:0] m,
                                                input logic [SEL_W-1:0]    cur);
      logic [SEL_W-1:0] r;
      logic             found;
      int               idx;
      r     = cur;
      found = 1'b0;
      for (int k = 1; k <= N_DIGITS; k++) begin
         idx = (int'(cur) + k) % N_DIGITS;
         if (!found && m[idx]) begin
            r     = SEL_W'(idx);
            found = 1'b1;
         end
      end
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_sel        <= '0;
         r_digit      <= '1;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_sel        <= w_sel_nxt;
         r_digit      <= w_digit_nxt;
         r_frame_done <= w_frame_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_sel_nxt   = r_sel;
      w_frame_nxt = 1'b0;
      w_digit_nxt = '1;
      w_run       = ON && (|mask);

      if (!w_run) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            IDLE: begin
               w_sel_nxt = f_lowest(mask);
               w_cnt_nxt = '0;
`ifdef DIGIT_SCAN_DEAD_TIME_EN
               w_state_nxt = DEAD;
`else
               w_state_nxt = DRIVE;
`endif
            end
`ifdef DIGIT_SCAN_DEAD_TIME_EN
            DEAD: begin
               if (r_cnt == CNT_W'(DEAD_CYCLES - 1)) begin
                  w_state_nxt = DRIVE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
`endif
            DRIVE: begin
               // A digit whose mask bit drops mid-dwell is abandoned at once.
               if (r_cnt == CNT_W'(DWELL_CYCLES - 1) || !mask[r_sel]) begin
                  w_sel_nxt   = f_next(mask, r_sel);
                  w_frame_nxt = (w_sel_nxt <= r_sel);
                  w_cnt_nxt   = '0;
`ifdef DIGIT_SCAN_DEAD_TIME_EN
                  w_state_nxt = DEAD;
`else
                  w_state_nxt = DRIVE;
`endif
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end

      if (w_state_nxt == DRIVE)
         w_digit_nxt = ~(ONE_HOT0 << w_sel_nxt);
   end

   assign digit      = r_digit;
   assign sel        = r_sel;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_digit_scan_driver.sv
// Directed self-checking bench for digit_scan_driver (N_DIGITS=4, DWELL=4, DEAD=2).
// Expectations follow DIGIT_SCAN_DEAD_TIME_EN: gap of 2 blank cycles when defined, none otherwise.
module tb_digit_scan_driver;

   localparam int N     = 4;
   localparam int DWELL = 4;
`ifdef DIGIT_SCAN_DEAD_TIME_EN
   localparam int GAP = 2;
`else
   localparam int GAP = 0;
`endif

   logic         clk;
   logic         rst_n;
   logic         ON;
   logic [N-1:0] mask;
   logic [N-1:0] digit;
   logic [1:0]   sel;
   logic         frame_done;

   int n_cmp = 0;
   int n_err = 0;

   digit_scan_driver #(.N_DIGITS(N), .DWELL_CYCLES(DWELL), .DEAD_CYCLES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ON         (ON),
      .mask       (mask),
      .digit      (digit),
      .sel        (sel),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full digit slot: GAP blank cycles then DWELL driven cycles; wrap marks the frame pulse.
   task automatic run_digit(input string tag, input int d, input bit wrap);
      logic [N-1:0] e;
      e    = '1;
      e[d] = 1'b0;
      for (int i = 0; i < GAP; i++) begin
         tick();
         chk({tag, ".gap.digit"}, 32'(digit), 32'hF);
         chk({tag, ".gap.sel"}, 32'(sel), 32'(d));
         chk({tag, ".gap.frame"}, 32'(frame_done), 32'(wrap && i == 0));
      end
      for (int i = 0; i < DWELL; i++) begin
         tick();
         chk({tag, ".drv.digit"}, 32'(digit), 32'(e));
         chk({tag, ".drv.sel"}, 32'(sel), 32'(d));
         chk({tag, ".drv.frame"}, 32'(frame_done), 32'(wrap && GAP == 0 && i == 0));
      end
   endtask

   task automatic go_idle();
      ON = 1'b0;
      tick();
      chk("idle.digit", 32'(digit), 32'hF);
      chk("idle.frame", 32'(frame_done), 32'h0);
   endtask

   initial begin
      rst_n = 1'b1;
      ON    = 1'b1;
      mask  = 4'b1111;
      #2 rst_n = 1'b0;
      #1;
      chk("rst.digit", 32'(digit), 32'hF);
      chk("rst.sel", 32'(sel), 32'h0);
      chk("rst.frame", 32'(frame_done), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst.hold.digit", 32'(digit), 32'hF);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel.digit", 32'(digit), 32'hF);

      // Full scan with all digits enabled, twice round
      run_digit("all.d0", 0, 1'b0);
      run_digit("all.d1", 1, 1'b0);
      run_digit("all.d2", 2, 1'b0);
      run_digit("all.d3", 3, 1'b0);
      run_digit("all2.d0", 0, 1'b1);
      run_digit("all2.d1", 1, 1'b0);
      run_digit("all2.d2", 2, 1'b0);
      run_digit("all2.d3", 3, 1'b0);

      // Sparse mask 0101
      go_idle();
      mask = 4'b0101;
      ON   = 1'b1;
      run_digit("m0101.d0", 0, 1'b0);
      run_digit("m0101.d2", 2, 1'b0);
      run_digit("m0101b.d0", 0, 1'b1);
      run_digit("m0101b.d2", 2, 1'b0);

      // ON dropped in the second dwell cycle of digit 1
      go_idle();
      mask = 4'b1111;
      ON   = 1'b1;
      run_digit("on.d0", 0, 1'b0);
      repeat (GAP) tick();
      tick();
      chk("on.dw1.digit", 32'(digit), 32'hD);
      tick();
      chk("on.dw2.digit", 32'(digit), 32'hD);
      ON = 1'b0;
      tick();
      chk("on.off.digit", 32'(digit), 32'hF);
      chk("on.off.frame", 32'(frame_done), 32'h0);
      tick();
      chk("on.off2.digit", 32'(digit), 32'hF);
      ON = 1'b1;
      run_digit("on.back.d0", 0, 1'b0);

      // Single enabled digit
      go_idle();
      mask = 4'b0100;
      ON   = 1'b1;
      run_digit("one.a", 2, 1'b0);
      run_digit("one.b", 2, 1'b1);
      run_digit("one.c", 2, 1'b1);

      // Mask bit of the driven digit cleared mid-dwell
      go_idle();
      mask = 4'b1111;
      ON   = 1'b1;
      run_digit("mk.d0", 0, 1'b0);
      repeat (GAP) tick();
      tick();
      chk("mk.dw1.digit", 32'(digit), 32'hD);
      mask = 4'b1101;
      run_digit("mk.d2", 2, 1'b0);
      run_digit("mk.d3", 3, 1'b0);
      run_digit("mk.d0b", 0, 1'b1);
      run_digit("mk.d2b", 2, 1'b0);

      // Empty mask with ON held high
      mask = 4'b0000;
      for (int i = 0; i < 100; i++) begin
         tick();
         chk("zero.digit", 32'(digit), 32'hF);
         chk("zero.frame", 32'(frame_done), 32'h0);
      end

      // Asynchronous reset mid-drive of digit 1
      mask = 4'b1111;
      run_digit("ar.d0", 0, 1'b0);
      repeat (GAP) tick();
      tick();
      tick();
      chk("ar.pre.digit", 32'(digit), 32'hD);
      chk("ar.pre.sel", 32'(sel), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar.digit", 32'(digit), 32'hF);
      chk("ar.sel", 32'(sel), 32'h0);
      chk("ar.frame", 32'(frame_done), 32'h0);
      tick();
      chk("ar.hold.digit", 32'(digit), 32'hF);
      @(negedge clk);
      rst_n = 1'b1;
      run_digit("ar.back.d0", 0, 1'b0);
      run_digit("ar.back.d1", 1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/digit_scan_driver.md
DIGIT_SCAN_DRIVER -- requirements
Module: digit_scan_driver

Interface
REQ-001 Parameter N_DIGITS, default 4: number of multiplexed display digits; legal range 2..16.
REQ-002 Parameter DWELL_CYCLES, default 50000: clock cycles each digit is driven; legal value >= 1.
REQ-003 Parameter DEAD_CYCLES, default 2: all-blank clock cycles between digits; legal value >= 1.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 ON  input  1  display enable; 0 blanks all digits.
REQ-007 mask  input  N_DIGITS  per-digit enable; 1 = digit takes part in the scan.
REQ-008 digit  output  N_DIGITS  digit drives, active-low, registered; 1 = off.
REQ-009 sel  output  $clog2(N_DIGITS)  index of the digit currently selected; segment-data mux select.
REQ-010 frame_done  output  1  one-cycle pulse when the scan wraps to the lowest enabled digit.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, DEAD and DRIVE.
REQ-012 In IDLE and DEAD, digit SHALL be all ones.
REQ-013 In DRIVE, digit[sel] SHALL be 0 and every other bit SHALL be 1.
REQ-014 IDLE -> DEAD occurs when ON=1 and mask!=0; on this transition sel SHALL load the lowest set index of mask.
REQ-015 DEAD -> DRIVE SHALL occur after exactly DEAD_CYCLES cycles in DEAD.
REQ-016 DRIVE -> DEAD SHALL occur after exactly DWELL_CYCLES cycles in DRIVE, so digit[sel] is low for exactly DWELL_CYCLES cycles.
REQ-017 On the DRIVE -> DEAD transition, sel SHALL advance to the next set mask bit above sel, searching circularly; the mask used is the value sampled on that edge.
REQ-018 frame_done SHALL be 1 for exactly the one cycle following an advance in which the new sel is less than or equal to the old sel; it is 0 at all other times.
REQ-019 With a single enabled digit, sel SHALL stay on that digit, the digit SHALL still blank for DEAD_CYCLES between dwells, and frame_done SHALL pulse on every advance.
REQ-020 If mask[sel] becomes 0 during DRIVE, the dwell SHALL end at the next edge and sel SHALL advance per REQ-017.
REQ-021 If ON=0 or mask=0 is sampled in any state, the next state SHALL be IDLE and digit SHALL be all ones from that edge on; the dwell and dead counters SHALL clear.
REQ-022 Every restart from IDLE SHALL begin at the lowest enabled digit with a full DEAD interval.
REQ-023 Counter widths SHALL be $clog2 of the larger of DWELL_CYCLES and DEAD_CYCLES (plus 1); counters SHALL never wrap inside an interval.

Reset
REQ-024 While rst_n=0, the block SHALL hold: state=IDLE, digit all ones, sel=0, frame_done=0, all counters 0. This takes effect immediately, without a clock edge.
REQ-025 After rst_n deasserts, the first state transition SHALL occur no earlier than the first rising clk edge.

Configuration
REQ-026 Macro DIGIT_SCAN_DEAD_TIME_EN.
- Defined: the DEAD state and DEAD_CYCLES operate as in REQ-011..REQ-022.
- Undefined: DEAD is removed; IDLE goes directly to DRIVE; DRIVE advances directly to DRIVE on the next digit with no blank cycles; DEAD_CYCLES is ignored.
- All other behaviour is identical in both builds.

Verification (N_DIGITS=4, DWELL_CYCLES=4, DEAD_CYCLES=2, macro defined unless noted)
REQ-027 Reset release, ON=1, mask=1111:
- digit runs 1111 x2, 1110 x4, 1111 x2, 1101 x4, 1111 x2, 1011 x4, 1111 x2, 0111 x4, then repeats.
- frame_done pulses once, on the cycle sel returns to 0.
REQ-028 mask=0101:
- digit alternates 1110 x4 and 1011 x4, with 1111 x2 between each.
- sel takes only the values 0 and 2.
REQ-029 ON dropped in the 2nd dwell cycle of digit 1:
- digit=1111 from the next edge.
- After ON returns to 1: digit 1111 x2, then 1110.
REQ-030 rst_n pulled low mid-DRIVE between clock edges:
- digit=1111, sel=0 and frame_done=0 immediately, before any clock edge.
REQ-031 mask=0000 with ON=1 for 100 cycles:
- digit stays 1111 throughout.
- frame_done stays 0.
REQ-032 Macro undefined, mask=1111:
- digit runs 1110 x4, 1101 x4, 1011 x4, 0111 x4 with no 1111 gaps between digits.
